// File: rtl/add_sub_fan_out_pipe_if.sv
// Operand/result handshake bundle for add_sub_fan_out_pipe.
// Producer-side valid/ready on the inputs, consumer-side valid/ready on the results.
interface add_sub_fan_out_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             sat_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             carry0;
    logic             borrow1;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in0, in1, sat_en, in_valid, out_ready,
        input  in_ready, out0, out1, carry0, borrow1, out_valid
    );

    modport slave (
        input  in0, in1, sat_en, in_valid, out_ready,
        output in_ready, out0, out1, carry0, borrow1, out_valid
    );
endinterface

// File: rtl/add_sub_fan_out_pipe.sv
// Sum/difference fan-out with optional saturation, carried through an elastic
// valid/ready pipeline of STAGES slots, plus a completed-transfer counter.
module add_sub_fan_out_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    add_sub_fan_out_pipe_if.slave bus,
    output logic [COUNT_W-1:0]    xfer_count
);
    typedef struct packed {
        logic             carry;
        logic             borrow;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] diff;
    } result_t;

    logic [WIDTH:0]    sum_w;
    result_t           entry;
    result_t           slot [STAGES];
    result_t           up_d [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] rdy;
    logic              full_tail;

    always_comb begin
        sum_w        = {1'b0, bus.in0} + {1'b0, bus.in1};
        entry.carry  = sum_w[WIDTH];
        entry.borrow = bus.in0 < bus.in1;
        entry.sum    = (bus.sat_en && entry.carry) ? '1 : sum_w[WIDTH-1:0];
        entry.diff   = (bus.sat_en && entry.borrow) ? '0 : bus.in0 - bus.in1;
    end

    // rdy_i = !v_i || rdy_{i+1} unrolled: slot i is blocked only when it and every
    // later slot are full and the consumer stalls; avoids a self-referencing vector.
    always_comb begin
        rdy       = '0;
        full_tail = 1'b1;
        for (int unsigned i = 0; i < STAGES; i++) begin
            full_tail = 1'b1;
            for (int unsigned j = i; j < STAGES; j++) begin
                full_tail = full_tail & v[j];
            end
            rdy[i] = bus.out_ready || !full_tail;
        end
    end

    always_comb begin
        up_v[0] = bus.in_valid;
        up_d[0] = entry;
        for (int unsigned i = 1; i < STAGES; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = slot[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v          <= '0;
            xfer_count <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        slot[i] <= up_d[i];
                    end
                end
            end
            if (v[STAGES-1] && bus.out_ready) begin
                xfer_count <= xfer_count + COUNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.out0      = slot[STAGES-1].sum;
    assign bus.out1      = slot[STAGES-1].diff;
    assign bus.carry0    = slot[STAGES-1].carry;
    assign bus.borrow1   = slot[STAGES-1].borrow;
endmodule

// File: tb/tb_add_sub_fan_out_pipe.sv
// Directed and reference-model checks of add_sub_fan_out_pipe in three
// configurations (8/2/16, 8/2/4 counter wrap, 1-bit single stage).
module tb_add_sub_fan_out_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] xc_a;
    logic [3:0]  xc_b;
    logic [15:0] xc_c;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [7:0]  va [256];
    logic [7:0]  vb [256];
    logic        vs [256];
    logic [17:0] q [$];

    always #5 clk = ~clk;

    add_sub_fan_out_pipe_if #(.WIDTH(8)) ia ();
    add_sub_fan_out_pipe_if #(.WIDTH(8)) ib ();
    add_sub_fan_out_pipe_if #(.WIDTH(1)) ic ();

    add_sub_fan_out_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia), .xfer_count(xc_a)
    );
    add_sub_fan_out_pipe #(.WIDTH(8), .STAGES(2), .COUNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib), .xfer_count(xc_b)
    );
    add_sub_fan_out_pipe #(.WIDTH(1), .STAGES(1), .COUNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ic), .xfer_count(xc_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference packing {carry, borrow, out1, out0} for WIDTH=8.
    function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [8:0] sm;
        logic [7:0] o0;
        logic [7:0] o1;
        logic       br;
        sm = {1'b0, a} + {1'b0, b};
        br = (a < b);
        o0 = (s && sm[8]) ? 8'hFF : sm[7:0];
        o1 = (s && br) ? 8'h00 : 8'(a - b);
        return {sm[8], br, o1, o0};
    endfunction

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic [17:0] exp);
        @(negedge clk);
        ia.out_ready = 1'b1;
        ia.in0 = a; ia.in1 = b; ia.sat_en = s; ia.in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(ia.in_ready), 32'd1);
        @(negedge clk);
        ia.in_valid = 1'b0;
        #1;
        check({tag, "_early"}, 32'(ia.out_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(ia.out_valid), 32'd1);
        check({tag, "_data"}, 32'({ia.carry0, ia.borrow1, ia.out1, ia.out0}), 32'(exp));
    endtask

    // mode 0: out_ready=1; 1: random out_ready and input gaps; 2: stall first 6 cycles
    task automatic run_stream(input string tag, input int n, input int mode, output int cycles);
        int sent = 0;
        int got = 0;
        q.delete();
        cycles = 0;
        while ((sent < n || got < n) && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            case (mode)
                0:       ia.out_ready = 1'b1;
                1:       ia.out_ready = 1'($urandom_range(0, 1));
                default: ia.out_ready = (cycles > 6);
            endcase
            ia.in_valid = (sent < n) && (mode != 1 || $urandom_range(0, 3) != 0);
            if (sent < n) begin
                ia.in0 = va[sent]; ia.in1 = vb[sent]; ia.sat_en = vs[sent];
            end
            #1;
            check({tag, "_in_ready"}, 32'(ia.in_ready), 32'((q.size() < 2) || ia.out_ready));
            if (q.size() == 0) begin
                check({tag, "_empty_valid"}, 32'(ia.out_valid), 32'd0);
            end else if (ia.out_valid) begin
                check({tag, "_data"}, 32'({ia.carry0, ia.borrow1, ia.out1, ia.out0}), 32'(q[0]));
                if (ia.out_ready) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            if (ia.in_valid && ia.in_ready) begin
                q.push_back(model(va[sent], vb[sent], vs[sent]));
                sent++;
            end
        end
        if (sent < n || got < n) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        ia.in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        ia.in0 = '0; ia.in1 = '0; ia.sat_en = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
        ib.in0 = '0; ib.in1 = '0; ib.sat_en = 1'b0; ib.in_valid = 1'b0; ib.out_ready = 1'b1;
        ic.in0 = '0; ic.in1 = '0; ic.sat_en = 1'b0; ic.in_valid = 1'b0; ic.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(ia.out_valid), 32'd0);
        check("rst_data", 32'({ia.carry0, ia.borrow1, ia.out1, ia.out0}), 32'd0);
        check("rst_count", 32'(xc_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", 32'(ia.in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            va[i] = 8'(i); vb[i] = 8'(i + 1); vs[i] = 1'b0;
        end
        run_stream("stream", 10, 0, cyc);
        check("stream_cycles", 32'(cyc), 32'd12);
        check("stream_count", 32'(xc_a), 32'd10);

        directed("add_carry", 8'd200, 8'd100, 1'b0, {1'b1, 1'b0, 8'd100, 8'd44});
        directed("add_sat", 8'd200, 8'd100, 1'b1, {1'b1, 1'b0, 8'd100, 8'd255});
        directed("sub_borrow", 8'd3, 8'd5, 1'b0, {1'b0, 1'b1, 8'd254, 8'd8});
        directed("sub_sat", 8'd3, 8'd5, 1'b1, {1'b0, 1'b1, 8'd0, 8'd8});

        va[0] = 8'd10;  vb[0] = 8'd20;  vs[0] = 1'b0;
        va[1] = 8'd250; vb[1] = 8'd9;   vs[1] = 1'b1;
        va[2] = 8'd7;   vb[2] = 8'd7;   vs[2] = 1'b0;
        va[3] = 8'd255; vb[3] = 8'd255; vs[3] = 1'b1;
        run_stream("bp", 4, 2, cyc);

        for (int i = 0; i < 200; i++) begin
            va[i] = 8'($urandom); vb[i] = 8'($urandom); vs[i] = 1'($urandom);
        end
        run_stream("rand", 200, 1, cyc);

        // two items in flight, then a one-cycle reset
        @(negedge clk);
        ia.out_ready = 1'b0; ia.in0 = 8'd9; ia.in1 = 8'd4; ia.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ia.in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", 32'(ia.out_valid), 32'd0);
        check("midrst_count", 32'(xc_a), 32'd0);
        check("midrst_in_ready", 32'(ia.in_ready), 32'd1);
        directed("after_rst", 8'd1, 8'd1, 1'b0, {1'b0, 1'b0, 8'd0, 8'd2});

        @(negedge clk);
        ib.in0 = 8'd1; ib.in1 = 8'd2; ib.in_valid = 1'b1; ib.out_ready = 1'b1;
        repeat (17) @(negedge clk);
        ib.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("wrap_count", 32'(xc_b), 32'd1);
        check("wrap_drained", 32'(ib.out_valid), 32'd0);

        @(negedge clk);
        ic.in0 = 1'b1; ic.in1 = 1'b1; ic.sat_en = 1'b0; ic.in_valid = 1'b1; ic.out_ready = 1'b1;
        @(negedge clk);
        ic.in_valid = 1'b0;
        #1;
        check("w1_valid", 32'(ic.out_valid), 32'd1);
        check("w1_data", 32'({ic.carry0, ic.borrow1, ic.out1, ic.out0}), 32'b1000);
        @(negedge clk);
        ic.out_ready = 1'b0; ic.in0 = 1'b1; ic.in1 = 1'b0; ic.sat_en = 1'b1; ic.in_valid = 1'b1;
        @(negedge clk);
        ic.in0 = 1'b0; ic.in1 = 1'b1;
        #1;
        check("w1_full_in_ready", 32'(ic.in_ready), 32'd0);
        check("w1_held", 32'({ic.carry0, ic.borrow1, ic.out1, ic.out0}), 32'b0011);
        ic.out_ready = 1'b1;
        #1;
        check("w1_pass_in_ready", 32'(ic.in_ready), 32'd1);
        @(negedge clk);
        ic.in_valid = 1'b0;
        #1;
        check("w1_sat_borrow", 32'({ic.carry0, ic.borrow1, ic.out1, ic.out0}), 32'b0101);
        check("w1_count", 32'(xc_c), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/add_sub_fan_out_pipe.md
Name: add_sub_fan_out_pipe

Overview:
- Parametrised successor to the fixed 2-bit registered add/sub fan-out block.
- Takes one operand pair per transaction and fans it out to two results: sum (in0+in1) and difference (in0-in1), with carry/borrow flags.
- Optional per-transaction saturation; results pass through an elastic valid/ready pipeline of configurable depth with full backpressure.
- Includes a completed-transaction counter.
- Sits between producer and consumer datapath stages in the CoreIR sample flow.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- STAGES, 2, number of pipeline register stages (>=1); equals zero-stall latency.
- COUNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in0  input  WIDTH  operand A, unsigned.
- in1  input  WIDTH  operand B, unsigned.
- sat_en  input  1  1 = saturate this transaction, 0 = wrap.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept the pair this cycle.
- out0  output  WIDTH  sum result.
- out1  output  WIDTH  difference result.
- carry0  output  1  unsigned carry out of in0+in1.
- borrow1  output  1  borrow of in0-in1 (in0<in1).
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- xfer_count  output  COUNT_W  number of completed output transfers, wraps.

Behaviour:
- Reset: one clock, one synchronous active-low reset, rst_n sampled on the rising edge of clk.
  - While rst_n=0: all stage valid bits, data registers, flags and xfer_count clear to 0.
  - So out_valid=0, out0=out1=0, carry0=borrow1=0, xfer_count=0.
  - in_ready is 1 in the first cycle after reset deasserts.
- Arithmetic: computed combinationally on inputs at stage-0 entry, then carried through the registers unchanged.
  - sum = WIDTH+1-bit in0+in1; carry0 = sum[WIDTH].
  - out0 = sum[WIDTH-1:0] if sat_en=0; out0 = all ones if sat_en=1 and carry0=1.
  - diff = in0-in1 modulo 2^WIDTH; borrow1 = (in0<in1).
  - out1 = diff if sat_en=0; out1 = 0 if sat_en=1 and borrow1=1.
  - Flags report the raw carry/borrow regardless of sat_en.
- Pipeline: STAGES register slots, slot STAGES-1 drives the outputs.
  - Slot i ready: rdy_i = !v_i || rdy_{i+1}, with rdy_STAGES = out_ready.
  - Slot i loads from slot i-1 (slot 0 from inputs) when rdy_i=1. Loaded valid = upstream valid; data loads only when upstream valid=1.
  - in_ready = rdy_0 (combinational from out_ready through the chain; no registered skid).
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - out_valid = v_{STAGES-1}. Outputs stay stable while out_valid=1 and out_ready=0.
  - Input is not consumed when in_ready=0.
- Latency and throughput:
  - Zero-stall latency = STAGES cycles: pair accepted at edge k appears at out_valid after edge k+STAGES-1.
  - Throughput 1 per cycle with out_ready held high.
  - Order preserved; no drop or duplication.
- Full and empty:
  - Pipeline holds at most STAGES items.
  - When all slots are valid and out_ready=0, in_ready=0.
  - Simultaneous output transfer and full pipeline: in_ready=1 in that same cycle.
  - Empty pipeline with in_valid=0: out_valid=0.
- xfer_count: increments by 1 on each output transfer; wraps from 2^COUNT_W-1 to 0.
- Reset mid-operation: all in-flight items are discarded, with no output transfer on the reset edge. Counter returns to 0.
- Width corners:
  - WIDTH=1 is legal.
  - in0=in1 gives diff 0 with borrow1=0.
  - Max operands give sum carry.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: in0=200, in1=100, sat_en=0 -> after 2 cycles out0=44, carry0=1, out1=100, borrow1=0; repeat with sat_en=1 -> out0=255, out1=100.
- in0=3, in1=5: sat_en=0 -> out1=254, borrow1=1, out0=8; sat_en=1 -> out1=0, borrow1=1, out0=8.
- Stream pairs (i, i+1) for i=0..9 with out_ready=1 -> one result per cycle, out0=2i+1, out1=255, borrow1=1, in order; xfer_count ends at 10.
- Backpressure: send 4 pairs with out_ready=0 -> after 2 accepts in_ready=0 and out0 holds stable. Raise out_ready -> all 4 results emerge in order, none lost or duplicated. Random out_ready toggling over 200 items matches a reference model.
- Assert rst_n=0 for one cycle with 2 items in flight -> next cycle out_valid=0, xfer_count=0, in_ready=1; a subsequent pair in0=1, in1=1 yields out0=2, out1=0.
- COUNT_W=4: 17 output transfers -> xfer_count=1. STAGES=1, WIDTH=1: in0=1, in1=1 -> out0=0, carry0=1, out1=0, next cycle.
